rs_free_list: RTL and testbench

Parametrised successor to the single-type reservation-station free-slot allocator. It is a circular free list of RS entry indices with ALLOC_W in-order allocate ports and RET_W return ports. It adds capacity-aware grants (no over-allocation), duplicate and illegal return detection via an in-use bitmap, and status outputs. It sits in Decode/ReservationStation, with one instance per RS type (ALU/LSU/BRU), between rename/dispatch and RS issue/wakeup.

---
 rtl/rs_pkg.sv | 31 +++
 rtl/prefix_count.sv | 23 ++
 rtl/rs_free_list.sv | 139 +++++++++++++
 tb/tb_rs_free_list.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared types and width helpers for the reservation-station free lists.
package rs_pkg;

  typedef enum logic [1:0] {
    RS_ALU = 2'd0,
    RS_LSU = 2'd1,
    RS_BRU = 2'd2
  } rs_type_e;

  localparam int unsigned AluEntries = 8;
  localparam int unsigned LsuEntries = 8;
  localparam int unsigned BruEntries = 4;

  function automatic int unsigned default_entries(input rs_type_e t);
    unique case (t)
      RS_ALU:  return AluEntries;
      RS_LSU:  return LsuEntries;
      RS_BRU:  return BruEntries;
      default: return AluEntries;
    endcase
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return idx_w(n) + 1;
  endfunction

endpackage

// File: rtl/prefix_count.sv
// Exclusive prefix popcount of a bit vector plus the total population count.
module prefix_count #(
  parameter int unsigned W  = 2,
  parameter int unsigned OW = $clog2(W + 1)
) (
  input  logic [W-1:0]    i_bits,
  output logic [W*OW-1:0] o_prefix,
  output logic [OW-1:0]   o_total
);

  logic [OW-1:0] w_acc;

  always_comb begin
    w_acc    = '0;
    o_prefix = '0;
    for (int i = 0; i < W; i++) begin
      o_prefix[i*OW +: OW] = w_acc;
      w_acc                = w_acc + OW'(i_bits[i]);
    end
    o_total = w_acc;
  end

endmodule

// File: rtl/rs_free_list.sv
// Circular free list of RS entry indices with in-order multi-port allocate and
// compacting multi-port return, guarded by an in-use bitmap.
module rs_free_list
  import rs_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned ALLOC_W     = 2,
  parameter int unsigned RET_W       = 2,
  parameter int unsigned TYPE        = 0,
  localparam int unsigned IW         = idx_w(NUM_ENTRIES),
  localparam int unsigned CW         = cnt_w(NUM_ENTRIES)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic [ALLOC_W-1:0]    i_alloc_req,
  output logic [ALLOC_W-1:0]    o_alloc_gnt,
  output logic [ALLOC_W*IW-1:0] o_alloc_idx,
  input  logic [RET_W-1:0]      i_ret_valid,
  input  logic [RET_W*IW-1:0]   i_ret_idx,
  output logic [CW-1:0]         o_num_free,
  output logic                  o_empty,
  output logic                  o_all_free,
  output logic                  o_ret_err
);

  localparam int unsigned AOW = $clog2(ALLOC_W + 1);
  localparam int unsigned ROW = $clog2(RET_W + 1);

  if (TYPE > 2 || NUM_ENTRIES < 2 || (NUM_ENTRIES & (NUM_ENTRIES - 1)) != 0 ||
      ALLOC_W < 1 || ALLOC_W > 4 || ALLOC_W > NUM_ENTRIES ||
      RET_W < 1 || RET_W > 4 || RET_W > NUM_ENTRIES) begin : g_param_err
    $error("rs_free_list: illegal parameter set");
  end

  logic [IW-1:0]          r_list [NUM_ENTRIES];
  logic [IW-1:0]          r_head;
  logic [CW-1:0]          r_num_free;
  logic [NUM_ENTRIES-1:0] r_in_use;
  logic                   r_ret_err;

  logic [ALLOC_W*AOW-1:0] w_k;
  logic [AOW-1:0]         w_req_total;
  logic [CW-1:0]          w_num_gnt;
  logic [RET_W-1:0]       w_accept;
  logic [RET_W*ROW-1:0]   w_ret_off;
  logic [ROW-1:0]         w_num_ret;
  logic [IW-1:0]          w_tail;
  logic [IW-1:0]          w_list_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] w_in_use_d;

  prefix_count #(
    .W  (ALLOC_W),
    .OW (AOW)
  ) u_alloc_pc (
    .i_bits   (i_alloc_req),
    .o_prefix (w_k),
    .o_total  (w_req_total)
  );

  always_comb begin
    o_alloc_gnt = '0;
    o_alloc_idx = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      if (i_alloc_req[i] && !i_flush && (CW'(w_k[i*AOW +: AOW]) < r_num_free)) begin
        o_alloc_gnt[i]          = 1'b1;
        o_alloc_idx[i*IW +: IW] = r_list[r_head + IW'(w_k[i*AOW +: AOW])];
      end
    end
  end

  // Grants form a prefix of the requesters, so their count is min(requests, free).
  assign w_num_gnt = (CW'(w_req_total) < r_num_free) ? CW'(w_req_total) : r_num_free;

  always_comb begin
    logic [RET_W-1:0] acc;
    acc = '0;
    for (int j = 0; j < RET_W; j++) begin
      acc[j] = i_ret_valid[j] && r_in_use[i_ret_idx[j*IW +: IW]];
      for (int p = 0; p < j; p++) begin
        if (acc[p] && (i_ret_idx[p*IW +: IW] == i_ret_idx[j*IW +: IW])) acc[j] = 1'b0;
      end
    end
    w_accept = acc;
  end

  prefix_count #(
    .W  (RET_W),
    .OW (ROW)
  ) u_ret_pc (
    .i_bits   (w_accept),
    .o_prefix (w_ret_off),
    .o_total  (w_num_ret)
  );

  assign w_tail = r_head + r_num_free[IW-1:0];

  always_comb begin
    w_list_d   = r_list;
    w_in_use_d = r_in_use;
    for (int i = 0; i < ALLOC_W; i++) begin
      if (o_alloc_gnt[i]) w_in_use_d[o_alloc_idx[i*IW +: IW]] = 1'b1;
    end
    for (int j = 0; j < RET_W; j++) begin
      if (w_accept[j]) begin
        w_list_d[w_tail + IW'(w_ret_off[j*ROW +: ROW])] = i_ret_idx[j*IW +: IW];
        w_in_use_d[i_ret_idx[j*IW +: IW]]               = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_list[i] <= IW'(i);
      r_head     <= '0;
      r_num_free <= CW'(NUM_ENTRIES);
      r_in_use   <= '0;
      r_ret_err  <= 1'b0;
    end else if (i_flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_list[i] <= IW'(i);
      r_head     <= '0;
      r_num_free <= CW'(NUM_ENTRIES);
      r_in_use   <= '0;
      r_ret_err  <= 1'b0;
    end else begin
      r_list     <= w_list_d;
      r_head     <= r_head + w_num_gnt[IW-1:0];
      r_num_free <= r_num_free - w_num_gnt + CW'(w_num_ret);
      r_in_use   <= w_in_use_d;
      r_ret_err  <= |(i_ret_valid & ~w_accept);
    end
  end

  assign o_num_free = r_num_free;
  assign o_empty    = (r_num_free == '0);
  assign o_all_free = (r_num_free == CW'(NUM_ENTRIES));
  assign o_ret_err  = r_ret_err;

endmodule

// File: tb/tb_rs_free_list.sv
// Bench for rs_free_list: directed vector table, async reset check, and
// randomized traffic against a queue-based free-list model.
module tb_rs_free_list;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 2;
  localparam int unsigned RW = 2;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [AW-1:0] req;
  logic [AW-1:0] gnt;
  logic [AW*IW-1:0] aidx;
  logic [RW-1:0] rv;
  logic [RW*IW-1:0] ridx;
  logic [CW-1:0] nf;
  logic          empty;
  logic          all_free;
  logic          ret_err;

  always #5 clk = ~clk;

  rs_free_list #(
    .NUM_ENTRIES (N),
    .ALLOC_W     (AW),
    .RET_W       (RW),
    .TYPE        (0)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .i_alloc_req (req),
    .o_alloc_gnt (gnt),
    .o_alloc_idx (aidx),
    .i_ret_valid (rv),
    .i_ret_idx   (ridx),
    .o_num_free  (nf),
    .o_empty     (empty),
    .o_all_free  (all_free),
    .o_ret_err   (ret_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: ordered queue of free indices plus an in-use set.
  int q[$];
  bit used[N];
  bit m_err;

  task automatic m_reset();
    q.delete();
    for (int i = 0; i < N; i++) begin
      q.push_back(i);
      used[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic m_expect(input logic [AW-1:0] r, input logic f,
                          output logic [AW-1:0] g, output logic [AW*IW-1:0] ix);
    int k;
    k  = 0;
    g  = '0;
    ix = '0;
    for (int i = 0; i < AW; i++) begin
      if (r[i] && !f && k < q.size()) begin
        g[i] = 1'b1;
        ix[i*IW +: IW] = IW'(q[k]);
      end
      if (r[i]) k++;
    end
  endtask

  task automatic m_update(input logic [AW-1:0] r, input logic [RW-1:0] v,
                          input logic [RW*IW-1:0] ri, input logic f);
    logic [AW-1:0] g;
    logic [AW*IW-1:0] ix;
    int acc[$];
    bit e;
    bit dup;
    int x;
    if (f) begin
      m_reset();
      return;
    end
    m_expect(r, f, g, ix);
    e = 1'b0;
    for (int j = 0; j < RW; j++) begin
      if (v[j]) begin
        x   = int'(ri[j*IW +: IW]);
        dup = 1'b0;
        foreach (acc[a]) if (acc[a] == x) dup = 1'b1;
        if (used[x] && !dup) acc.push_back(x);
        else e = 1'b1;
      end
    end
    for (int i = 0; i < $countones(g); i++) used[q.pop_front()] = 1'b1;
    foreach (acc[a]) begin
      used[acc[a]] = 1'b0;
      q.push_back(acc[a]);
    end
    m_err = e;
  endtask

  task automatic apply(input logic [AW-1:0] r, input logic [RW-1:0] v,
                       input logic [RW*IW-1:0] ri, input logic f);
    req   = r;
    rv    = v;
    ridx  = ri;
    flush = f;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    m_update(req, rv, ridx, flush);
    #1;
  endtask

  typedef struct {
    logic [1:0]    req;
    logic [1:0]    rv;
    logic [2:0]    r0;
    logic [2:0]    r1;
    logic          fl;
    logic [1:0]    gnt;
    logic [2:0]    i0;
    logic [2:0]    i1;
    logic [CW-1:0] nf;
    logic          err;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [AW-1:0] eg;
    logic [AW*IW-1:0] ei;
    logic [AW-1:0] r;
    logic [RW-1:0] v;
    logic [RW*IW-1:0] ri;
    logic f;
    int x;
    bit found;

    //         req    rv     r0 r1 fl   gnt    i0 i1 nf err
    tbl[0]  = '{2'b11, 2'b00, 0, 0, 0, 2'b11, 0, 1, 8, 0};
    tbl[1]  = '{2'b11, 2'b00, 0, 0, 0, 2'b11, 2, 3, 6, 0};
    tbl[2]  = '{2'b11, 2'b00, 0, 0, 0, 2'b11, 4, 5, 4, 0};
    tbl[3]  = '{2'b11, 2'b00, 0, 0, 0, 2'b11, 6, 7, 2, 0};
    tbl[4]  = '{2'b00, 2'b11, 5, 2, 0, 2'b00, 0, 0, 0, 0};
    tbl[5]  = '{2'b11, 2'b00, 0, 0, 0, 2'b11, 5, 2, 2, 0};
    tbl[6]  = '{2'b00, 2'b11, 3, 3, 0, 2'b00, 0, 0, 0, 0};
    tbl[7]  = '{2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 1};
    tbl[8]  = '{2'b00, 2'b01, 3, 0, 0, 2'b00, 0, 0, 1, 0};
    tbl[9]  = '{2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 1};
    tbl[10] = '{2'b11, 2'b01, 6, 0, 0, 2'b01, 3, 0, 1, 0};
    tbl[11] = '{2'b10, 2'b00, 0, 0, 0, 2'b10, 0, 6, 1, 0};
    tbl[12] = '{2'b11, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0};
    tbl[13] = '{2'b11, 2'b11, 0, 1, 1, 2'b00, 0, 0, 0, 0};
    tbl[14] = '{2'b11, 2'b00, 0, 0, 0, 2'b11, 0, 1, 8, 0};

    rst   = 1'b1;
    flush = 1'b0;
    req   = '0;
    rv    = '0;
    ridx  = '0;
    m_reset();
    #12;
    chk("reset num_free", nf, 8);
    chk("reset empty", empty, 0);
    chk("reset all_free", all_free, 1);
    chk("reset ret_err", ret_err, 0);
    chk("reset gnt", gnt, 0);
    chk("reset idx", aidx, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int t = 0; t < 15; t++) begin
      apply(tbl[t].req, tbl[t].rv, {tbl[t].r1, tbl[t].r0}, tbl[t].fl);
      chk($sformatf("row%0d gnt", t), gnt, tbl[t].gnt);
      chk($sformatf("row%0d idx0", t), aidx[2:0], tbl[t].i0);
      chk($sformatf("row%0d idx1", t), aidx[5:3], tbl[t].i1);
      chk($sformatf("row%0d num_free", t), nf, tbl[t].nf);
      chk($sformatf("row%0d empty", t), empty, tbl[t].nf == 0);
      chk($sformatf("row%0d all_free", t), all_free, tbl[t].nf == 8);
      chk($sformatf("row%0d ret_err", t), ret_err, tbl[t].err);
      advance();
    end

    // Async reset between edges with requests still asserted.
    chk("pre-rst num_free", nf, 6);
    #1 rst = 1'b1;
    #1;
    chk("async rst num_free", nf, 8);
    chk("async rst all_free", all_free, 1);
    chk("async rst gnt", gnt, 2'b11);
    chk("async rst idx", aidx, {3'd1, 3'd0});
    chk("async rst ret_err", ret_err, 0);
    rst = 1'b0;
    m_reset();

    for (int c = 0; c < 600; c++) begin
      r = AW'($urandom);
      v = RW'($urandom);
      for (int j = 0; j < RW; j++) begin
        x = $urandom_range(0, N - 1);
        if ($urandom_range(0, 3) != 0) begin
          found = 1'b0;
          for (int s = 0; s < N; s++) begin
            if (!found && used[(x + s) % N]) begin
              x     = (x + s) % N;
              found = 1'b1;
            end
          end
        end
        ri[j*IW +: IW] = IW'(x);
      end
      f = ($urandom_range(0, 39) == 0);
      apply(r, v, ri, f);
      m_expect(r, f, eg, ei);
      chk($sformatf("rnd%0d gnt", c), gnt, eg);
      chk($sformatf("rnd%0d idx", c), aidx, ei);
      chk($sformatf("rnd%0d num_free", c), nf, q.size());
      chk($sformatf("rnd%0d empty", c), empty, q.size() == 0);
      chk($sformatf("rnd%0d all_free", c), all_free, q.size() == N);
      chk($sformatf("rnd%0d ret_err", c), ret_err, m_err);
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
